// File: rtl/sync_edge_filter.sv
// sync_edge_filter: per-channel multi-flop synchronizer with optional debounce
// filter and one-cycle rise/fall pulse generation.
// Optional feature macro: SYNC_FILTER_EN (debounce filter compiled in when defined).
// Without the macro, out follows the last synchronizer stage directly and
// FILTER_LEN has no effect.
module sync_edge_filter #(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // Reject nonsensical parameter sets at elaboration time.
  if (WIDTH < 1 || STAGES < 2 || FILTER_LEN < 1) begin : g_bad_params
    $error("sync_edge_filter: WIDTH>=1, STAGES>=2 and FILTER_LEN>=1 required");
  end

  logic [WIDTH-1:0] sync_q;   // last synchronizer stage of every channel
  logic [WIDTH-1:0] out_d_q;  // out delayed by one cycle (the out_d history flop)
  logic [WIDTH-1:0] out_d_d;

  genvar gi;

  // Synchronizer chains: plain shift of flops, nothing between stages.
  for (gi = 0; gi < WIDTH; gi++) begin : g_sync
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Next chain value: shift the raw input in at stage 0.
    always_comb begin
      chain_d = {chain_q[STAGES-2:0], in[gi]};
    end

    // Chain flops, forced to the channel's reset value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chain_q <= {STAGES{RESET_VAL[gi]}};
      end else begin
        chain_q <= chain_d;
      end
    end

    assign sync_q[gi] = chain_q[STAGES-1];
  end

`ifdef SYNC_FILTER_EN
  // A counter of this width reaches FILTER_LEN-1 and is cleared before it
  // could ever wrap, so no saturation logic is required.
  localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Debounce: out only takes a new value once sync_q has differed from it
  // for FILTER_LEN consecutive cycles; any shorter excursion is dropped.
  for (gi = 0; gi < WIDTH; gi++) begin : g_filt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             filt_q;
    logic             filt_d;

    // Count cycles of disagreement; commit the new level on the last one.
    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_q[gi] != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_d = sync_q[gi];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end

    // Filter state flops; reset discards any partially counted interval.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        filt_q <= RESET_VAL[gi];
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign out[gi] = filt_q;
  end
`else
  // No filter: the synchronized level is the output.
  assign out = sync_q;
`endif

  // History of out for edge detection.
  always_comb begin
    out_d_d = out;
  end

  // out_d flops; matching out at reset so no pulse appears on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_d_q <= RESET_VAL;
    end else begin
      out_d_q <= out_d_d;
    end
  end

  // Pulses are decoded purely from flop outputs: one cycle wide, aligned
  // with the first cycle of the new out value, mutually exclusive per bit.
  assign rise    = out & ~out_d_q;
  assign fall    = ~out & out_d_q;
  assign changed = |(rise | fall);

endmodule

// File: tb/tb_sync_edge_filter.sv
// Testbench for sync_edge_filter (WIDTH=4, STAGES=2, FILTER_LEN=4).
// Two instances: RESET_VAL=0 and RESET_VAL=F, sharing in/rst_n.
// Expected values come from a window-based reference model.
module tb_sync_edge_filter;

  localparam int         W   = 4;
  localparam int         STG = 2;
  localparam int         FL  = 4;
  localparam logic [3:0] RV0 = 4'h0;
  localparam logic [3:0] RV1 = 4'hF;
`ifdef SYNC_FILTER_EN
  localparam int LAT = STG + FL;
`else
  localparam int LAT = STG;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_r = '0;
  logic [W-1:0] out0, rise0, fall0;
  logic [W-1:0] out1, rise1, fall1;
  logic         changed0, changed1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: xh[e] = input seen at edge e after release (e>=1);
  // om[i][c] = expected out of instance i during cycle c.
  logic [3:0] xh [0:2047];
  logic [3:0] om [0:1][0:2047];

  sync_edge_filter #(.WIDTH(W), .STAGES(STG), .FILTER_LEN(FL), .RESET_VAL(RV0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in_r),
    .out(out0), .rise(rise0), .fall(fall0), .changed(changed0)
  );

  sync_edge_filter #(.WIDTH(W), .STAGES(STG), .FILTER_LEN(FL), .RESET_VAL(RV1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in_r),
    .out(out1), .rise(rise1), .fall(fall1), .changed(changed1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Synchronized level during cycle c: the input captured STAGES-1 edges earlier.
  function automatic logic [3:0] sync_m(input int c, input logic [3:0] rv);
    int e;
    e = c - STG + 1;
    if (e >= 1) return xh[e];
    return rv;
  endfunction

  function automatic logic [3:0] rv_of(input int i);
    return (i == 0) ? RV0 : RV1;
  endfunction

  function automatic logic [3:0] prev_m(input int i, input int c);
    return (c == 0) ? rv_of(i) : om[i][c-1];
  endfunction

  // Filtered: a bit flips once the previous FL synced samples all disagree
  // with its current value. Unfiltered: out is the synced level.
  task automatic model_update(input int c);
    logic [3:0] prev, flip;
    for (int i = 0; i < 2; i++) begin
      prev = prev_m(i, c);
      if (c == 0) begin
        om[i][0] = rv_of(i);
      end else begin
`ifdef SYNC_FILTER_EN
        flip = 4'hF;
        for (int j = 1; j <= FL; j++) flip &= sync_m(c - j, rv_of(i)) ^ prev;
        om[i][c] = prev ^ flip;
`else
        flip = 4'h0;
        om[i][c] = sync_m(c, rv_of(i)) ^ flip;
`endif
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] e_out, e_rise, e_fall;
    for (int i = 0; i < 2; i++) begin
      e_out  = om[i][cyc];
      e_rise = e_out & ~prev_m(i, cyc);
      e_fall = ~e_out & prev_m(i, cyc);
      if (i == 0) begin
        check("m0_out", out0, e_out);
        check("m0_rise", rise0, e_rise);
        check("m0_fall", fall0, e_fall);
        check("m0_changed", changed0, |(e_rise | e_fall));
      end else begin
        check("m1_out", out1, e_out);
        check("m1_rise", rise1, e_rise);
        check("m1_fall", fall1, e_fall);
        check("m1_changed", changed1, |(e_rise | e_fall));
      end
    end
  endtask

  // Assert reset #1 after an edge, check async clear, release after 'hold' edges.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_out0", out0, RV0);
    check("rst_out1", out1, RV1);
    check("rst_pulse0", {changed0, rise0, fall0}, 9'h0);
    check("rst_pulse1", {changed1, rise1, fall1}, 9'h0);
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    model_update(0);
    check_all();
    $display("reset released: in %h out0 %h out1 %h", in_r, out0, out1);
  endtask

  // Advance one clock, record the captured input, then check the cycle.
  task automatic step();
    @(posedge clk);
    xh[cyc+1] = in_r;
    cyc++;
    #1;
    model_update(cyc);
    check_all();
    $display("cyc %0d in %h | out0 %h r %h f %h | out1 %h r %h f %h",
             cyc, in_r, out0, rise0, fall0, out1, rise1, fall1);
  endtask

  initial begin
    // Basic transition 0->A then A->5 (simultaneous rise/fall on other bits).
    in_r = 4'h0;
    do_reset(2);
    in_r = 4'hA;
    for (int k = 0; k < 12; k++) begin
      step();
      check("s1_out", out0, (cyc >= LAT) ? 4'hA : 4'h0);
      check("s1_rise", rise0, (cyc == LAT) ? 4'hA : 4'h0);
    end
    in_r = 4'h5;
    for (int k = 0; k < 12; k++) begin
      step();
      check("s1b_out", out0, (cyc >= 12 + LAT) ? 4'h5 : 4'hA);
      check("s1b_rise", rise0, (cyc == 12 + LAT) ? 4'h5 : 4'h0);
      check("s1b_fall", fall0, (cyc == 12 + LAT) ? 4'hA : 4'h0);
    end

    // Short glitch on bit 1, then a held level.
    in_r = 4'h0;
    do_reset(2);
    in_r = 4'h2;
    for (int k = 0; k < 12; k++) begin
      step();
      if (cyc == 3) in_r = 4'h0;
`ifdef SYNC_FILTER_EN
      check("s2_glitch_out", out0, 4'h0);
      check("s2_glitch_rise", rise0, 4'h0);
`endif
    end
    in_r = 4'h2;
    for (int k = 0; k < 12; k++) begin
      step();
      check("s2_out", out0, (cyc >= 12 + LAT) ? 4'h2 : 4'h0);
      check("s2_rise", rise0, (cyc == 12 + LAT) ? 4'h2 : 4'h0);
    end

    // RESET_VAL=F instance with in=0 through reset.
    in_r = 4'h0;
    do_reset(2);
    for (int k = 0; k < 10; k++) begin
      step();
      check("s3_out1", out1, (cyc >= LAT) ? 4'h0 : 4'hF);
      check("s3_fall1", fall1, (cyc == LAT) ? 4'hF : 4'h0);
      check("s3_rise1", rise1, 4'h0);
    end

    // Reset while bit 0 is mid-count; a full interval is needed afterwards.
    in_r = 4'h0;
    do_reset(2);
    in_r = 4'h1;
    for (int k = 0; k < 3; k++) step();
    do_reset(2);
    for (int k = 0; k < 10; k++) begin
      step();
      check("s4_out", out0, (cyc >= LAT) ? 4'h1 : 4'h0);
      check("s4_rise", rise0, (cyc == LAT) ? 4'h1 : 4'h0);
    end

    // Bit 3 toggling every cycle.
    in_r = 4'h0;
    do_reset(2);
    in_r = 4'h8;
    for (int k = 0; k < 20; k++) begin
      step();
      in_r = in_r ^ 4'h8;
`ifdef SYNC_FILTER_EN
      check("s5_out3", out0 & 4'h8, 4'h0);
      check("s5_edge3", (rise0 | fall0) & 4'h8, 4'h0);
`endif
    end

    // Random: mostly-held levels with occasional changes and resets.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (r < 30) begin
        in_r = 4'($urandom);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_edge_filter.md
SYNC_EDGE_FILTER -- requirements
Module: sync_edge_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of independent single-bit channels (>=1).
REQ-002 SHALL have parameter STAGES, default 2: synchronizer flop depth per channel (>=2).
REQ-003 SHALL have parameter FILTER_LEN, default 4: consecutive cycles of a stable new value required before out changes (>=1; used only with SYNC_FILTER_EN).
REQ-004 SHALL have parameter RESET_VAL, default {WIDTH{1'b0}}: reset value of the sync chain, out and internal history.
REQ-005 SHALL have port clk  input  1  sole clock; all flops on posedge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in  input  WIDTH  asynchronous level inputs, one per channel.
REQ-008 SHALL have port out  output  WIDTH  synchronized (optionally filtered) level.
REQ-009 SHALL have port rise  output  WIDTH  one-cycle pulse per channel on an out 0->1 transition.
REQ-010 SHALL have port fall  output  WIDTH  one-cycle pulse per channel on an out 1->0 transition.
REQ-011 SHALL have port changed  output  1  OR-reduction of (rise | fall).

Function
REQ-012 SHALL pass each in bit through STAGES cascaded flops; the last stage is sync_q; no logic between stages.
REQ-013 SHALL hold each channel's state independently; channels share only clk and rst_n.
REQ-014 SHALL, with filter compiled in, keep a per-channel counter of width max(1,$clog2(FILTER_LEN)), saturation never needed.
REQ-015 SHALL clear that counter in any cycle where sync_q equals out.
REQ-016 SHALL increment the counter in any cycle where sync_q differs from out and the counter is below FILTER_LEN-1.
REQ-017 SHALL, when sync_q differs from out and counter equals FILTER_LEN-1, load out with sync_q and clear the counter.
REQ-018 SHALL therefore give filtered latency in-to-out of STAGES+FILTER_LEN clk cycles and reject any sync_q excursion shorter than FILTER_LEN cycles.
REQ-019 SHALL, with filter compiled out, drive out directly from sync_q (latency STAGES cycles) and instantiate no counters.
REQ-020 SHALL keep out_d, a one-cycle registered copy of out.
REQ-021 SHALL drive rise = out & ~out_d and fall = ~out & out_d, decoded only from flops, each exactly one cycle wide, coincident with the first cycle of the new out value.
REQ-022 SHALL never assert rise and fall on the same bit in the same cycle.
REQ-023 SHALL handle simultaneous transitions on several channels with independent pulses in the same cycle.

Reset
REQ-024 SHALL, while rst_n is low, asynchronously force all sync flops, out and out_d to RESET_VAL and all counters to 0.
REQ-025 SHALL hold rise, fall, changed at 0 during reset and in the first cycle after release.
REQ-026 SHALL discard any partially counted filter interval on reset mid-operation; a full FILTER_LEN interval is required after release.
REQ-027 SHALL release reset synchronously to clk (deassertion synchronized externally).

Configuration
REQ-028 SHALL compile the debounce filter (REQ-014..REQ-018) only when macro SYNC_FILTER_EN is defined.
REQ-029 SHALL, without SYNC_FILTER_EN, behave as REQ-019 with identical ports, and FILTER_LEN SHALL be ignored.

Verification (WIDTH=4, STAGES=2, FILTER_LEN=4, RESET_VAL=4'h0 unless stated)
REQ-030 SHALL cover: filter off, in 4'h0->4'h1 at cycle 0 -> out=4'h1 from cycle 2, rise=4'h1 for cycle 2 only, changed=1 cycle 2 only.
REQ-031 SHALL cover: filter on, in[1] high 3 cycles then low -> out stays 4'h0, no pulses; in[1] held high -> out=4'h2 from cycle 6, rise=4'h2 one cycle.
REQ-032 SHALL cover: filter on, in 4'h0->4'hA -> out=4'hA at cycle 6, rise=4'hA one cycle; in 4'hA->4'h5 -> rise=4'h5 and fall=4'hA same cycle.
REQ-033 SHALL cover: filter on, rst_n pulsed low while a channel counter=2 -> out=4'h0 immediately, no pulses after release, change needs 4 further stable cycles.
REQ-034 SHALL cover: RESET_VAL=4'hF, in=4'h0 through reset -> out=4'hF after reset with no pulse; fall=4'hF one cycle at cycle 6 (filter on) or 2 (filter off).
REQ-035 SHALL cover: filter on, in[3] toggling every cycle for 20 cycles -> out[3] constant, rise[3]=fall[3]=0 throughout.
